// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared constants and types for the NCO clock-enable generator
package clk_pkg;

  localparam int ACC_W_DEF = 24;

  typedef logic [ACC_W_DEF-1:0] acc_t;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } settle_state_e;

endpackage

// File: rtl/clk_nco_chan.sv
// rtl/clk_nco_chan.sv - one NCO channel: phase accumulator, increment register, carry strobe
// Optional square output under CLK_SQ_OUT_EN.
module clk_nco_chan
  import clk_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_DEFAULT = '0
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic             wr_phase_rst,
  output logic             clk_en
`ifdef CLK_SQ_OUT_EN
  ,
  output logic             clk_sq
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // The add in a write cycle still uses the old increment.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      acc    <= '0;
      inc    <= INC_DEFAULT;
      clk_en <= 1'b0;
    end else begin
      if (wr) begin
        inc <= wr_inc;
      end
      if (wr && wr_phase_rst) begin
        acc    <= '0;
        clk_en <= 1'b0;
      end else begin
        acc    <= sum[ACC_W-1:0];
        clk_en <= sum[ACC_W];
      end
    end
  end

`ifdef CLK_SQ_OUT_EN
  always_ff @(posedge sys_clk) begin
    if (rst || (wr && wr_phase_rst)) begin
      clk_sq <= 1'b0;
    end else begin
      clk_sq <= acc[ACC_W-1];
    end
  end
`endif

endmodule

// File: rtl/clk_nco_gen.sv
// rtl/clk_nco_gen.sv - multi-channel NCO clock-enable generator with settle/lock and peripheral reset
// Define CLK_SQ_OUT_EN to add the per-channel clk_sq square-wave outputs.
module clk_nco_gen
  import clk_pkg::*;
#(
  parameter int               NCH         = 4,
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_DEFAULT = '0,
  parameter int               SETTLE_CYC  = 16,
  localparam int              SEL_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_phase_rst,
  output logic [NCH-1:0]   clk_en,
  output logic             locked,
  output logic             rst_out
`ifdef CLK_SQ_OUT_EN
  ,
  output logic [NCH-1:0]   clk_sq
`endif
);

  localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  logic [NCH-1:0] hit;
  logic           wr_valid;

  // Out-of-range selects match no channel, so they neither write nor restart settle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = cfg_we && (cfg_sel == SEL_W'(i));
    end
  end

  assign wr_valid = |hit;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_nco_chan #(
      .ACC_W       (ACC_W),
      .INC_DEFAULT (INC_DEFAULT)
    ) u_chan (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .wr           (hit[g]),
      .wr_inc       (cfg_inc),
      .wr_phase_rst (cfg_phase_rst),
      .clk_en       (clk_en[g])
`ifdef CLK_SQ_OUT_EN
      ,
      .clk_sq       (clk_sq[g])
`endif
    );
  end

  settle_state_e    state;
  settle_state_e    state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rst_out_nxt;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= SETTLE;
      cnt     <= CNT_LOAD;
      rst_out <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_out <= rst_out_nxt;
    end
  end

  // rst_out only ever clears, on the first entry to LOCKED after reset.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rst_out_nxt = rst_out;
    case (state)
      SETTLE: begin
        if (wr_valid) begin
          cnt_nxt = CNT_LOAD;
        end else if (cnt == '0) begin
          state_nxt   = LOCKED;
          rst_out_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      LOCKED: begin
        if (wr_valid) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_LOAD;
        end
      end
    endcase
  end

  assign locked = (state == LOCKED);

endmodule
